// File: rtl/potential_decay_pkg.sv
// Shared definitions for the potential decay array: rate codes, IEEE-754
// single-precision field positions, the float typedef and the sweep FSM states.
package potential_decay_pkg;

   localparam logic [3:0] RATE_DIV1 = 4'b0001;
   localparam logic [3:0] RATE_DIV2 = 4'b0010;
   localparam logic [3:0] RATE_DIV4 = 4'b0100;
   localparam logic [3:0] RATE_DIV8 = 4'b1000;
   localparam logic [3:0] RATE_MIX  = 4'b0011;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MANT_MSB = 22;
   localparam int MANT_LSB = 0;

   typedef logic [31:0] float32_t;

   typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

endpackage

// File: rtl/float_decay_unit.sv
// Combinational decay of one single-precision potential by its rate code.
// Optional macro POTENTIAL_DECAY_MIX_EN enables the x0.75 (x/2 + x/4) mode;
// without it code 0011 passes the value through unchanged.
module float_decay_unit
   import potential_decay_pkg::*;
(
   input  float32_t   pot_i,
   input  logic [3:0] rate_i,
   output float32_t   pot_o
);

   logic        sign;
   logic [7:0]  exp_f;
   logic [22:0] mant;
   logic [1:0]  shift;
   logic        special;

   assign sign    = pot_i[SIGN_BIT];
   assign exp_f   = pot_i[EXP_MSB:EXP_LSB];
   assign mant    = pot_i[MANT_MSB:MANT_LSB];
   // Inf/NaN and zero/denormal are never touched
   assign special = (exp_f == 8'hFF) || (exp_f == 8'h00);

   // Map the power-of-two rate codes onto an exponent decrement
   always_comb begin
      case (rate_i)
         RATE_DIV1: shift = 2'd0;
         RATE_DIV2: shift = 2'd1;
         RATE_DIV4: shift = 2'd2;
         RATE_DIV8: shift = 2'd3;
         default:   shift = 2'd0;
      endcase
   end

`ifdef POTENTIAL_DECAY_MIX_EN
   logic [23:0] sig;
   logic [24:0] mix_sum;

   // Significand with hidden bit plus itself halved: 1.5*s, truncated
   assign sig     = {1'b1, mant};
   assign mix_sum = {1'b0, sig} + {2'b00, sig[23:1]};
`endif

   // Select the decayed result; flush to +0 when the exponent would underflow
   always_comb begin
      pot_o = pot_i;
      if (special) begin
         pot_o = pot_i;
      end
`ifdef POTENTIAL_DECAY_MIX_EN
      else if (rate_i == RATE_MIX) begin
         if (mix_sum[24])
            pot_o = {sign, exp_f, mix_sum[23:1]};
         else if (exp_f <= 8'd1)
            pot_o = '0;
         else
            pot_o = {sign, exp_f - 8'd1, mix_sum[22:0]};
      end
`endif
      else if (shift != 2'd0) begin
         if (exp_f <= {6'b0, shift})
            pot_o = '0;
         else
            pot_o = {sign, exp_f - {6'b0, shift}, mant};
      end
   end

endmodule

// File: rtl/potential_decay_array.sv
// Potential/rate store for NUM_NEURONS neurons with a timestep-triggered
// decay sweep (one neuron per cycle, write-back plus output stream).
// Optional macro POTENTIAL_DECAY_MIX_EN enables the x0.75 rate code.
module potential_decay_array
   import potential_decay_pkg::*;
#(
   parameter int unsigned NUM_NEURONS     = 16,
   parameter int unsigned ADDR_W          = $clog2(NUM_NEURONS),
   parameter logic [31:0] RESET_POTENTIAL = 32'h0000_0000,
   parameter logic [3:0]  DEFAULT_RATE    = 4'b0010
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [31:0]       cfg_potential,
   input  logic [3:0]        cfg_rate,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic [31:0]       upd_potential,
   input  logic              time_step,
   output logic              busy,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_potential,
   output logic              done,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

   float32_t          pot_q  [NUM_NEURONS];
   logic [3:0]        rate_q [NUM_NEURONS];
   state_e            state_q;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              out_valid_q, done_q, overrun_q;
   logic [ADDR_W-1:0] out_addr_q;
   float32_t          out_pot_q;
   float32_t          decayed;

   assign idx_d = idx_q + 1'b1;

   float_decay_unit u_decay (
      .pot_i  (pot_q[idx_q]),
      .rate_i (rate_q[idx_q]),
      .pot_o  (decayed)
   );

   assign busy          = (state_q == ST_SWEEP);
   assign upd_ready     = (state_q == ST_IDLE);
   assign out_valid     = out_valid_q;
   assign out_addr      = out_addr_q;
   assign out_potential = out_pot_q;
   assign done          = done_q;
   assign overrun       = overrun_q;

   // Sweep FSM: walk indices 0..N-1 and register each decayed value out
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_pot_q   <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (time_step) begin
                  state_q <= ST_SWEEP;
                  idx_q   <= '0;
               end
            end
            ST_SWEEP: begin
               if (time_step) overrun_q <= 1'b1;
               out_valid_q <= 1'b1;
               out_addr_q  <= idx_q;
               out_pot_q   <= decayed;
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Storage: sweep write-back while busy; adder update then cfg (cfg wins) when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot_q[i]  <= RESET_POTENTIAL;
            rate_q[i] <= DEFAULT_RATE;
         end
      end else if (state_q == ST_SWEEP) begin
         pot_q[idx_q] <= decayed;
      end else begin
         if (upd_valid) pot_q[upd_addr] <= upd_potential;
         if (cfg_we) begin
            pot_q[cfg_addr]  <= cfg_potential;
            rate_q[cfg_addr] <= cfg_rate;
         end
      end
   end

endmodule

// File: tb/tb_potential_decay_array.sv
// Directed bench for potential_decay_array (N=16) with hand-computed values.
module tb_potential_decay_array;

   localparam int N = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst, cfg_we, upd_valid, time_step;
   logic [AW-1:0] cfg_addr, upd_addr;
   logic [31:0]   cfg_potential, upd_potential;
   logic [3:0]    cfg_rate;
   logic          upd_ready, busy, out_valid, done, overrun;
   logic [AW-1:0] out_addr;
   logic [31:0]   out_potential;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] obs [N];
   int busy_cnt, done_cnt, beats, first_c, done_c, ready_c;
   logic seq_ok, done_ok;

   potential_decay_array #(.NUM_NEURONS(N)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_potential(cfg_potential), .cfg_rate(cfg_rate),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_potential(upd_potential),
      .time_step(time_step), .busy(busy),
      .out_valid(out_valid), .out_addr(out_addr), .out_potential(out_potential),
      .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input int a, input logic [31:0] p, input logic [3:0] r);
      cfg_we = 1'b1; cfg_addr = AW'(a); cfg_potential = p; cfg_rate = r;
      tick();
      cfg_we = 1'b0;
   endtask

   // Pulse time_step (any pre-set upd_valid rides along) and record the sweep
   task automatic do_sweep();
      busy_cnt = 0; done_cnt = 0; beats = 0; first_c = -1; done_c = -1; ready_c = -1;
      seq_ok = 1'b1; done_ok = 1'b1;
      for (int i = 0; i < N; i++) obs[i] = 32'hDEAD_BEEF;
      time_step = 1'b1;
      tick();
      time_step = 1'b0; upd_valid = 1'b0;
      for (int c = 1; c <= N + 2; c++) begin
         if (busy) busy_cnt++;
         if (out_valid) begin
            if (first_c < 0) first_c = c;
            if (int'(out_addr) != beats) seq_ok = 1'b0;
            obs[out_addr] = out_potential;
            if (done != (beats == N - 1)) done_ok = 1'b0;
            beats++;
         end else if (done) begin
            done_ok = 1'b0;
         end
         if (done) begin done_cnt++; done_c = c; end
         if (upd_ready && ready_c < 0) ready_c = c;
         tick();
      end
   endtask

   initial begin
      int dn;
      rst = 1'b1; cfg_we = 1'b0; upd_valid = 1'b0; time_step = 1'b0;
      cfg_addr = '0; upd_addr = '0; cfg_potential = '0; upd_potential = '0; cfg_rate = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'd0);
      chk("rst_out_pot", out_potential, 32'h0);
      chk("rst_upd_ready", 32'(upd_ready), 32'd1);

      // divide by 2 plus full sweep timing
      cfg_write(0, 32'h41DEB852, 4'b0010);
      do_sweep();
      chk("div2", obs[0], 32'h415EB852);
      chk("reset_entry", obs[1], 32'h0);
      chk("first_beat_cycle", 32'(first_c), 32'd2);
      chk("busy_cycles", 32'(busy_cnt), 32'd16);
      chk("beats", 32'(beats), 32'd16);
      chk("addr_seq", 32'(seq_ok), 32'd1);
      chk("done_align", 32'(done_ok), 32'd1);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_c), 32'd17);
      chk("ready_return", 32'(ready_c), 32'd17);

      cfg_write(0, 32'h41DEB852, 4'b0100);
      do_sweep();
      chk("div4", obs[0], 32'h40DEB852);
      cfg_write(0, 32'h41DEB852, 4'b1000);
      do_sweep();
      chk("div8", obs[0], 32'h405EB852);
      cfg_write(0, 32'h41DEB852, 4'b0011);
      do_sweep();
`ifdef POTENTIAL_DECAY_MIX_EN
      chk("mix", obs[0], 32'h41A70A3D);
`else
      chk("mix_off", obs[0], 32'h41DEB852);
`endif

      // boundaries
      cfg_write(1, 32'h00800000, 4'b0010);
      cfg_write(2, 32'h7F800000, 4'b1000);
      cfg_write(3, 32'hBF800000, 4'b0100);
      cfg_write(4, 32'h01000000, 4'b1000);
      do_sweep();
      chk("flush_min", obs[1], 32'h0);
      chk("inf_pass", obs[2], 32'h7F800000);
      chk("neg_div4", obs[3], 32'hBE800000);
      chk("flush_exp2_shift3", obs[4], 32'h0);

      // write-back across consecutive sweeps
      cfg_write(0, 32'h41DEB852, 4'b0010);
      do_sweep();
      do_sweep();
      chk("writeback", obs[0], 32'h40DEB852);

      // update together with time_step in idle: sweep sees the new value
      cfg_write(0, 32'h41DEB852, 4'b0010);
      upd_valid = 1'b1; upd_addr = 4'd0; upd_potential = 32'h3F800000;
      do_sweep();
      chk("upd_with_ts", obs[0], 32'h3F000000);

      // cfg wins over an update to the same address
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_potential = 32'h40400000; cfg_rate = 4'b0001;
      upd_valid = 1'b1; upd_addr = 4'd0; upd_potential = 32'h40800000;
      tick();
      cfg_we = 1'b0; upd_valid = 1'b0;
      do_sweep();
      chk("cfg_wins", obs[0], 32'h40400000);

      // update blocked during sweep; time_step while busy sets overrun
      time_step = 1'b1;
      tick();
      time_step = 1'b0;
      upd_valid = 1'b1; upd_addr = 4'd0; upd_potential = 32'h12345678;
      chk("upd_ready_busy", 32'(upd_ready), 32'd0);
      tick();
      time_step = 1'b1;
      tick();
      time_step = 1'b0; upd_valid = 1'b0;
      chk("overrun_set", 32'(overrun), 32'd1);
      for (int i = 0; i < N + 2; i++) tick();
      chk("no_resweep", 32'(busy), 32'd0);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      do_sweep();
      chk("store_kept", obs[0], 32'h40400000);

      // reset at T+5 aborts the sweep
      dn = 0;
      time_step = 1'b1;
      tick();
      time_step = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (done) dn++;
         tick();
      end
      if (done) dn++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_addr", 32'(out_addr), 32'd0);
      chk("abort_out_pot", out_potential, 32'h0);
      chk("abort_overrun", 32'(overrun), 32'd0);
      for (int c = 0; c < N + 4; c++) begin
         if (done || busy) dn++;
         tick();
      end
      chk("abort_no_done", 32'(dn), 32'd0);

      // after reset: entries back to RESET_POTENTIAL and rates to DEFAULT_RATE
      upd_valid = 1'b1; upd_addr = 4'd5; upd_potential = 32'h41DEB852;
      do_sweep();
      chk("post_rst_entry0", obs[0], 32'h0);
      chk("post_rst_default_rate", obs[5], 32'h415EB852);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
